// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, datapath widths,
// ALU select codes and the captured-operation payload.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [SEL_W-1:0] SEL_ADD  = 4'h0;
  localparam logic [SEL_W-1:0] SEL_SUB  = 4'h1;
  localparam logic [SEL_W-1:0] SEL_AND  = 4'h2;
  localparam logic [SEL_W-1:0] SEL_OR   = 4'h3;
  localparam logic [SEL_W-1:0] SEL_XOR  = 4'h4;
  localparam logic [SEL_W-1:0] SEL_NOT  = 4'h5;
  localparam logic [SEL_W-1:0] SEL_SHL  = 4'h6;
  localparam logic [SEL_W-1:0] SEL_SHR  = 4'h7;
  localparam logic [SEL_W-1:0] SEL_MUL  = 4'h8;
  localparam logic [SEL_W-1:0] SEL_INC  = 4'h9;
  localparam logic [SEL_W-1:0] SEL_DEC  = 4'hA;
  localparam logic [SEL_W-1:0] SEL_SWAP = 4'hB;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              bin;
    logic [SEL_W-1:0]  sel;
  } alu_op_t;

  // Saturating increment used by the drop counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU; out2 carries the high byte for MUL and the
// swapped operand for SWAP, cout is carry or borrow depending on the op.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              bin,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              cout
);

  logic [DATA_W:0]     sum9;
  logic [DATA_W:0]     dif9;
  logic [DATA_W:0]     inc9;
  logic [DATA_W:0]     dec9;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    sum9 = 9'(a) + 9'(b) + 9'(cin);
    dif9 = 9'(a) - 9'(b) - 9'(bin);
    inc9 = 9'(a) + 9'd1;
    dec9 = 9'(a) - 9'd1;
    prod = 16'(a) * 16'(b);
  end

  always_comb begin
    out1 = '0;
    out2 = '0;
    cout = 1'b0;
    case (sel)
      SEL_ADD:  {cout, out1} = sum9;
      SEL_SUB:  {cout, out1} = dif9;
      SEL_AND:  out1 = a & b;
      SEL_OR:   out1 = a | b;
      SEL_XOR:  out1 = a ^ b;
      SEL_NOT:  out1 = ~a;
      SEL_SHL:  {cout, out1} = {a, cin};
      SEL_SHR:  {out1, cout} = {cin, a};
      SEL_MUL:  {out2, out1} = prod;
      SEL_INC:  {cout, out1} = inc9;
      SEL_DEC:  {cout, out1} = dec9;
      SEL_SWAP: begin
        out1 = b;
        out2 = a;
      end
      default: begin
        out1 = '0;
        out2 = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared alu_8bit: accept one
// operation, execute it for one cycle, then hold the result until taken or timed out.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r0_cin,
  input  logic              r0_bin,
  input  logic [SEL_W-1:0]  r0_sel,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic              r1_cin,
  input  logic              r1_bin,
  input  logic [SEL_W-1:0]  r1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out1,
  output logic [DATA_W-1:0] rsp_out2,
  output logic              rsp_cout,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Counter value in the last RESP cycle before the result is dropped.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              prio_q;
  alu_op_t           op_q;
  logic              id_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_out1_q;
  logic [DATA_W-1:0] rsp_out2_q;
  logic              rsp_cout_q;
  logic              busy_q;
  logic              timeout_err_q;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic [CNT_W-1:0]  tmo_cnt_q;

  alu_op_t           req0;
  alu_op_t           req1;
  alu_op_t           op_d;
  logic              gnt_id_d;
  logic              in_idle;
  logic              accept;
  logic [DATA_W-1:0] alu_out1;
  logic [DATA_W-1:0] alu_out2;
  logic              alu_cout;

  assign req0 = {r0_a, r0_b, r0_cin, r0_bin, r0_sel};
  assign req1 = {r1_a, r1_b, r1_cin, r1_bin, r1_sel};

  // Round-robin grant: a lone requester wins, a tie goes to prio_q.
  always_comb begin
    gnt_id_d = 1'b0;
    if (r0_valid && r1_valid) begin
      gnt_id_d = prio_q;
    end else if (r1_valid) begin
      gnt_id_d = 1'b1;
    end
    in_idle  = rst_n && (state_q == ST_IDLE);
    r0_ready = in_idle && r0_valid && !gnt_id_d;
    r1_ready = in_idle && r1_valid &&  gnt_id_d;
    accept   = r0_ready || r1_ready;
    op_d     = gnt_id_d ? req1 : req0;
  end

  alu_8bit u_alu (
    .a    (op_q.a),
    .b    (op_q.b),
    .cin  (op_q.cin),
    .bin  (op_q.bin),
    .sel  (op_q.sel),
    .out1 (alu_out1),
    .out2 (alu_out2),
    .cout (alu_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      prio_q        <= 1'b0;
      op_q          <= '0;
      id_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_out1_q    <= '0;
      rsp_out2_q    <= '0;
      rsp_cout_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_d;
            id_q    <= gnt_id_d;
            prio_q  <= ~gnt_id_d;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_out1_q  <= alu_out1;
          rsp_out2_q  <= alu_out2;
          rsp_cout_q  <= alu_cout;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          tmo_cnt_q   <= '0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // A handshake on the final cycle takes priority over the drop.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            drop_cnt_q    <= sat_inc(drop_cnt_q);
            state_q       <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_out1    = rsp_out1_q;
  assign rsp_out2    = rsp_out2_q;
  assign rsp_cout    = rsp_cout_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, cycles rsp_valid may stay unaccepted before the result is dropped (legal 1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 rK_valid  in  1  requester K (K=0,1) presents an operation.
REQ-005 rK_ready  out  1  arbiter accepts requester K's operation this cycle.
REQ-006 rK_a, rK_b  in  8 each  ALU operands.
REQ-007 rK_cin, rK_bin  in  1 each  carry-in / borrow-in.
REQ-008 rK_sel  in  4  ALU operation select.
REQ-009 rsp_valid  out  1  result available; rsp_ready  in  1  consumer accepts result.
REQ-010 rsp_id  out  1  index of the requester that owns the result.
REQ-011 rsp_out1, rsp_out2  out  8 each; rsp_cout  out  1; registered ALU outputs.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 timeout_err  out  1  one-cycle pulse when a result is dropped.
REQ-014 drop_cnt  out  8  saturating count of dropped results.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-016 IDLE: rK_ready SHALL be high only for the granted requester and only while its rK_valid is high; the handshake (valid&&ready) captures a, b, cin, bin, sel and the requester id, then transitions to EXEC.
REQ-017 Arbitration SHALL be round-robin: a lone valid requester is granted; with both valid, grant goes to the requester not granted at the last accept; after reset the priority is r0.
REQ-018 The priority pointer SHALL update only on an accept handshake.
REQ-019 EXEC: captured operands drive the alu_8bit instance for exactly one cycle; out1, out2 and cout are registered into the rsp_* registers; the FSM transitions to RESP.
REQ-020 RESP: rsp_valid SHALL be high; rsp_* and rsp_id SHALL hold stable until rsp_valid drops.
REQ-021 On rsp_valid&&rsp_ready the FSM SHALL return to IDLE; a new accept is possible the following cycle (minimum 3 cycles per operation).
REQ-022 Latency: accept at cycle T gives rsp_valid high at T+2.
REQ-023 In RESP a timeout counter SHALL count cycles without rsp_ready; when it equals TIMEOUT the FSM SHALL drop the result, return to IDLE, pulse timeout_err for one cycle and increment drop_cnt (saturating at 255).
REQ-024 If rsp_ready rises in the same cycle the counter reaches TIMEOUT, the handshake SHALL win: no drop and no timeout_err.
REQ-025 The timeout counter SHALL clear on entering RESP.
REQ-026 rK_valid changes outside IDLE SHALL have no effect; both rK_ready SHALL be low in EXEC and RESP.

Reset
REQ-027 While rst_n is low at a clock edge: state IDLE, priority r0, rsp_valid 0, rsp_id 0, rsp_out1/out2 0x00, rsp_cout 0, timeout_err 0, drop_cnt 0, timeout counter 0.
REQ-028 A reset asserted mid-operation SHALL abandon the operation with no rsp_valid, no timeout_err and no drop_cnt change.
REQ-029 Combinationally, rK_ready SHALL be low while rst_n is low.

Structure
REQ-030 A shared package alu_pkg SHALL hold the FSM state encoding, the operand/select widths (8, 4) and the sel code constants used by alu_8bit.
REQ-031 The block SHALL instantiate the existing alu_8bit unmodified as its single sub-module, with bin routed to its bin port.

Verification
REQ-032 r0 only: a=0x12, b=0x34, cin=0, sel=4'h0 -> r0_ready at T, rsp_valid at T+2, rsp_id=0, rsp outputs equal alu_8bit model outputs for those inputs.
REQ-033 r0 and r1 both valid continuously for 4 ops, rsp_ready=1 -> grant order r0, r1, r0, r1 with 3-cycle spacing.
REQ-034 rsp_ready held low with TIMEOUT=15 -> rsp_valid high for 15 cycles, then timeout_err one-cycle pulse, drop_cnt 0->1, busy low.
REQ-035 rsp_ready asserted exactly on the TIMEOUT cycle -> normal handshake, timeout_err stays 0, drop_cnt unchanged.
REQ-036 rst_n low during EXEC -> next cycle IDLE, rsp_valid 0, no response ever issued for that operation; priority back to r0.
REQ-037 256 forced timeouts -> drop_cnt saturates at 0xFF.
